// File: rtl/cc_pkg.sv
// Shared types and defaults for the coprocessor memory arbiter.
package cc_pkg;

    typedef logic [31:0] cc_addr_t;
    typedef logic [31:0] cc_data_t;
    typedef logic [2:0]  cc_size_t;

    localparam int CC_MAX_OUTSTANDING = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } cc_gnt_state_e;

endpackage

// File: rtl/cc_tag_fifo.sv
// In-order FIFO of requester tags, one entry per issued memory command.
module cc_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [TW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag;
    end

endmodule

// File: rtl/cc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between coprocessor
// requesters; responses are steered back in order via a tag FIFO.
module cc_mem_arbiter
    import cc_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = CC_MAX_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   s_cmd_valid,
    output logic [NUM_REQ-1:0]   s_cmd_ready,
    input  logic [NUM_REQ*32-1:0] s_cmd_addr,
    input  logic [NUM_REQ-1:0]   s_cmd_read,
    input  logic [NUM_REQ*32-1:0] s_cmd_wdata,
    input  logic [NUM_REQ*3-1:0] s_cmd_size,
    output logic [NUM_REQ-1:0]   s_rsp_valid,
    input  logic [NUM_REQ-1:0]   s_rsp_ready,
    output cc_data_t             s_rsp_rdata,
    output logic                 s_rsp_err,
    output logic                 m_cmd_valid,
    input  logic                 m_cmd_ready,
    output cc_addr_t             m_cmd_addr,
    output logic                 m_cmd_read,
    output cc_data_t             m_cmd_wdata,
    output cc_size_t             m_cmd_size,
    input  logic                 m_rsp_valid,
    output logic                 m_rsp_ready,
    input  cc_data_t             m_rsp_rdata,
    input  logic                 m_rsp_err,
    output logic                 spurious_rsp
);

    localparam int TW = $clog2(NUM_REQ);

    cc_gnt_state_e state_q, state_d;
    logic [TW-1:0] gnt_q, gnt_d;
    logic [TW-1:0] rr_q, rr_d;
    logic [TW-1:0] rr_pick, gnt;
    logic          spur_q, spur_d;
    logic          cmd_fire, rsp_pop;
    logic          full, empty;
    logic [TW-1:0] head;

    // Scan downwards so the last hit is the first valid at/after rr_q.
    always_comb begin
        int j;
        j       = 0;
        rr_pick = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (s_cmd_valid[j]) rr_pick = TW'(j);
        end
    end

    assign gnt         = (state_q == LOCKED) ? gnt_q : rr_pick;
    assign m_cmd_valid = !rst && s_cmd_valid[gnt] && !full;
    assign m_cmd_addr  = s_cmd_addr[32*gnt +: 32];
    assign m_cmd_read  = s_cmd_read[gnt];
    assign m_cmd_wdata = s_cmd_wdata[32*gnt +: 32];
    assign m_cmd_size  = s_cmd_size[3*gnt +: 3];
    assign cmd_fire    = m_cmd_valid && m_cmd_ready;

    always_comb begin
        s_cmd_ready = '0;
        if (cmd_fire) s_cmd_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (m_cmd_valid && !m_cmd_ready) begin
                    state_d = LOCKED;
                    gnt_d   = gnt;
                end
            end
            LOCKED: begin
                if (cmd_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cmd_fire) begin
            rr_d = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
        end
    end

    always_comb begin
        s_rsp_valid = '0;
        m_rsp_ready = 1'b1;
        if (!empty) begin
            s_rsp_valid[head] = m_rsp_valid;
            m_rsp_ready       = s_rsp_ready[head];
        end
    end

    assign rsp_pop      = m_rsp_valid && m_rsp_ready && !empty;
    assign spur_d       = m_rsp_valid && empty;
    assign spurious_rsp = spur_q;
    assign s_rsp_rdata  = m_rsp_rdata;
    assign s_rsp_err    = m_rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            spur_q  <= spur_d;
        end
    end

    cc_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TW    (TW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_fire),
        .push_tag (gnt),
        .pop      (rsp_pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

endmodule
